// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared definitions for the memory access controller: access length
//   encodings, FSM state encoding and the alignment check used on accept.
package mem_access_ctrl_pkg;

  localparam logic [1:0] LOAD_STORE_BYTE = 2'd0;
  localparam logic [1:0] LOAD_STORE_HALF = 2'd1;
  localparam logic [1:0] LOAD_STORE_WORD = 2'd2;

  typedef enum logic [1:0] {
    MAC_IDLE = 2'd0,
    MAC_RD   = 2'd1,
    MAC_WR   = 2'd2,
    MAC_RESP = 2'd3
  } mac_state_e;

  // A half may sit at offsets 0..2 (it never crosses the word); a word must
  // be aligned. The unused length code is treated like a word.
  function automatic logic is_misaligned(input logic [1:0] offset,
                                         input logic [1:0] len);
    logic bad;
    case (len)
      LOAD_STORE_BYTE: bad = 1'b0;
      LOAD_STORE_HALF: bad = (offset == 2'd3);
      default:         bad = (offset != 2'd0);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_store.sv
// mem_access_ctrl_load_store (LoadStore)
//   Sub-word datapath, purely combinational.
//   dataIn       : full memory word
//   offset       : byte offset within the word
//   readLen      : length for the load extract
//   signExtend   : sign-extend byte/half loads
//   readDataOut  : extracted, right-justified load result
//   writeLen     : length for the store merge
//   writeData    : right-justified store data
//   writeDataOut : dataIn with the addressed lanes replaced by writeData
module mem_access_ctrl_load_store
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] dataIn,
  input  logic [1:0]  offset,
  input  logic [1:0]  readLen,
  input  logic        signExtend,
  output logic [31:0] readDataOut,
  input  logic [1:0]  writeLen,
  input  logic [31:0] writeData,
  output logic [31:0] writeDataOut
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  assign shamt   = {offset, 3'b000};
  assign shifted = dataIn >> shamt;

  always_comb begin
    readDataOut = dataIn;
    case (readLen)
      LOAD_STORE_BYTE: readDataOut = {{24{signExtend & shifted[7]}},  shifted[7:0]};
      LOAD_STORE_HALF: readDataOut = {{16{signExtend & shifted[15]}}, shifted[15:0]};
      default:         readDataOut = dataIn;
    endcase
  end

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (writeLen)
      LOAD_STORE_BYTE: lane_mask = 32'h0000_00FF << shamt;
      LOAD_STORE_HALF: lane_mask = 32'h0000_FFFF << shamt;
      default:         lane_mask = 32'hFFFF_FFFF;
    endcase
    writeDataOut = (dataIn & ~lane_mask) | ((writeData << shamt) & lane_mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one CPU load/store at a time onto a word-wide, word-aligned
//   bus. Sub-word stores become read-modify-write. Misaligned accesses and
//   bus timeouts complete with respError.
//   CPU side : reqValid/reqReady handshake, reqWrite, reqAddr, reqLen,
//              reqSignExtend, reqWData; respValid pulse with respData/respError
//   Bus side : memAddr, memRead, memWrite, memWData, memRData, memAck
//   TIMEOUT_CYCLES : strobe-high cycles without memAck before abort (0 = off)
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   MAC_IDLE | ready for a request
//   MAC_RD   | word read (load, or first half of a sub-word store)
//   MAC_WR   | word write (word store, or merged sub-word store)
//   MAC_RESP | one-cycle response pulse is being presented
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [1:0]  reqLen,
  input  logic        reqSignExtend,
  input  logic [31:0] reqWData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck
);

  localparam int CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TMO_EN   = (TIMEOUT_CYCLES > 0);

  mac_state_e  state_q, state_d;
  logic [1:0]  offset_q, offset_d;
  logic [1:0]  len_q, len_d;
  logic        write_q, write_d;
  logic        sext_q, sext_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_reg_q, data_reg_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  logic        strobe;
  logic        bus_ack;
  logic        expire;
  logic [31:0] ls_data_in;
  logic [31:0] ls_rdata;
  logic [31:0] ls_wdata;

  assign strobe  = mem_read_q | mem_write_q;
  assign bus_ack = memAck & strobe;
  // Counter only advances while a strobe is up, so it measures bus wait.
  assign expire  = TMO_EN && strobe && !memAck &&
                   (tmo_cnt_q == CNT_W'(TMO_LAST));

  // The read word feeds LoadStore directly on the ack so the load result and
  // the store merge are ready on the same edge the read completes.
  assign ls_data_in = (state_q == MAC_RD && bus_ack) ? memRData : data_reg_q;

  mem_access_ctrl_load_store u_load_store (
    .dataIn       (ls_data_in),
    .offset       (offset_q),
    .readLen      (len_q),
    .signExtend   (sext_q),
    .readDataOut  (ls_rdata),
    .writeLen     (len_q),
    .writeData    (wdata_q),
    .writeDataOut (ls_wdata)
  );

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    len_d        = len_q;
    write_d      = write_q;
    sext_d       = sext_q;
    wdata_d      = wdata_q;
    data_reg_d   = data_reg_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    tmo_cnt_d    = strobe ? tmo_cnt_q + CNT_W'(1) : tmo_cnt_q;

    case (state_q)
      MAC_IDLE: begin
        if (reqValid) begin
          offset_d   = reqAddr[1:0];
          len_d      = reqLen;
          write_d    = reqWrite;
          sext_d     = reqSignExtend;
          wdata_d    = reqWData;
          mem_addr_d = {reqAddr[31:2], 2'b00};
          tmo_cnt_d  = '0;
          if (is_misaligned(reqAddr[1:0], reqLen)) begin
            state_d      = MAC_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (reqWrite && reqLen == LOAD_STORE_WORD) begin
            state_d     = MAC_WR;
            mem_wdata_d = reqWData;
          end else begin
            state_d = MAC_RD;
          end
        end
      end

      MAC_RD: begin
        if (!strobe) begin
          mem_read_d = 1'b1;
        end else if (bus_ack) begin
          mem_read_d = 1'b0;
          data_reg_d = memRData;
          if (write_q) begin
            // Hand straight over to the write phase to save a cycle.
            state_d     = MAC_WR;
            mem_wdata_d = ls_wdata;
            mem_write_d = 1'b1;
            tmo_cnt_d   = '0;
          end else begin
            state_d      = MAC_RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = ls_rdata;
          end
        end else if (expire) begin
          mem_read_d   = 1'b0;
          state_d      = MAC_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end
      end

      MAC_WR: begin
        if (!strobe) begin
          mem_write_d = 1'b1;
        end else if (bus_ack) begin
          mem_write_d  = 1'b0;
          state_d      = MAC_RESP;
          resp_valid_d = 1'b1;
        end else if (expire) begin
          mem_write_d  = 1'b0;
          state_d      = MAC_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end
      end

      MAC_RESP: begin
        state_d = MAC_IDLE;
      end

      default: begin
        state_d = MAC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= MAC_IDLE;
      offset_q     <= '0;
      len_q        <= '0;
      write_q      <= 1'b0;
      sext_q       <= 1'b0;
      wdata_q      <= '0;
      data_reg_q   <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      len_q        <= len_d;
      write_q      <= write_d;
      sext_q       <= sext_d;
      wdata_q      <= wdata_d;
      data_reg_q   <= data_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign reqReady  = (state_q == MAC_IDLE);
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign respError = resp_error_q;
  assign memAddr   = mem_addr_q;
  assign memRead   = mem_read_q;
  assign memWrite  = mem_write_q;
  assign memWData  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reqValid, reqWrite, reqSignExtend, memAck;
  logic [31:0] reqAddr, reqWData, memRData;
  logic [1:0]  reqLen;

  logic        a_reqReady, a_respValid, a_respError, a_memRead, a_memWrite;
  logic [31:0] a_respData, a_memAddr, a_memWData;
  logic        b_reqReady, b_respValid, b_respError, b_memRead, b_memWrite;
  logic [31:0] b_respData, b_memAddr, b_memWData;

  logic        use_b = 1'b0;
  logic        m_reqReady, m_respValid, m_respError, m_memRead, m_memWrite;
  logic [31:0] m_respData, m_memAddr, m_memWData;

  assign m_reqReady  = use_b ? b_reqReady  : a_reqReady;
  assign m_respValid = use_b ? b_respValid : a_respValid;
  assign m_respError = use_b ? b_respError : a_respError;
  assign m_respData  = use_b ? b_respData  : a_respData;
  assign m_memRead   = use_b ? b_memRead   : a_memRead;
  assign m_memWrite  = use_b ? b_memWrite  : a_memWrite;
  assign m_memAddr   = use_b ? b_memAddr   : a_memAddr;
  assign m_memWData  = use_b ? b_memWData  : a_memWData;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .reset_n(reset_n), .reqValid(reqValid), .reqReady(a_reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqLen(reqLen),
    .reqSignExtend(reqSignExtend), .reqWData(reqWData),
    .respValid(a_respValid), .respData(a_respData), .respError(a_respError),
    .memAddr(a_memAddr), .memRead(a_memRead), .memWrite(a_memWrite),
    .memWData(a_memWData), .memRData(memRData), .memAck(memAck)
  );

  mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .reset_n(reset_n), .reqValid(reqValid), .reqReady(b_reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqLen(reqLen),
    .reqSignExtend(reqSignExtend), .reqWData(reqWData),
    .respValid(b_respValid), .respData(b_respData), .respError(b_respError),
    .memAddr(b_memAddr), .memRead(b_memRead), .memWrite(b_memWrite),
    .memWData(b_memWData), .memRData(memRData), .memAck(memAck)
  );

  typedef struct {
    bit          use_b;
    bit          write;
    logic [31:0] addr;
    logic [1:0]  len;
    bit          sext;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
    int          exp_reads;
    int          exp_writes;
    int          exp_rdc;
    int          exp_wrc;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
  } vec_t;

  int checks = 0;
  int failures = 0;

  int          got_lat, got_reads, got_writes, got_rdc, got_wrc;
  logic [31:0] got_data, got_addr, got_wdata;
  logic        got_err, got_tail, both_high, unstable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(a_reqReady && b_reqReady) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=busy expected=idle");
    end
  endtask

  // Issues one request and plays a memory that acks each strobe after
  // v.delay wait cycles. Called and returns just after a falling edge.
  task automatic do_txn(input vec_t v);
    bit          done = 0, in_phase = 0;
    int          wait_cnt = 0;
    logic [31:0] ph_addr = '0, ph_wdata = '0;
    wait_idle();
    use_b = v.use_b;
    got_lat = -1; got_reads = 0; got_writes = 0; got_rdc = 0; got_wrc = 0;
    got_data = 32'hX; got_err = 1'bx; got_addr = '0; got_wdata = '0;
    both_high = 0; unstable = 0;
    reqValid = 1; reqWrite = v.write; reqAddr = v.addr; reqLen = v.len;
    reqSignExtend = v.sext; reqWData = v.wdata;
    @(negedge clk);
    reqValid = 0;
    for (int n = 1; n <= 200 && !done; n++) begin
      if (m_memRead && m_memWrite) both_high = 1;
      if (m_memRead)  got_rdc++;
      if (m_memWrite) got_wrc++;
      if ((m_memRead || m_memWrite) && !in_phase) begin
        in_phase = 1; wait_cnt = 0; ph_addr = m_memAddr; ph_wdata = m_memWData;
      end else if (m_memRead || m_memWrite) begin
        if (m_memAddr !== ph_addr || (m_memWrite && m_memWData !== ph_wdata)) unstable = 1;
      end
      if (m_respValid) begin
        got_lat = n; got_data = m_respData; got_err = m_respError; done = 1;
      end
      memAck = 0;
      if (m_memRead || m_memWrite) begin
        if (wait_cnt == v.delay) begin
          memAck = 1; memRData = v.rdata; got_addr = m_memAddr; in_phase = 0;
          if (m_memRead) got_reads++;
          else begin
            got_writes++; got_wdata = m_memWData;
          end
        end else begin
          wait_cnt++;
        end
      end
      @(negedge clk);
    end
    memAck = 0;
    got_tail = m_respValid;
  endtask

  vec_t vecs[15];

  initial begin
    #400000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // use_b wr  addr          len   sx wdata          rdata          dly   exp_data      err lat rd wr rdc wrc exp_addr      exp_wdata
    vecs[0]  = '{0, 0, 32'h0000_0103, 2'd0, 1, 32'h0,          32'h8011_2233, 0,    32'hFFFF_FF80, 0, 3,  1, 0, 1,  0,  32'h0000_0100, 32'h0};
    vecs[1]  = '{0, 0, 32'h0000_0103, 2'd0, 0, 32'h0,          32'h8011_2233, 0,    32'h0000_0080, 0, 3,  1, 0, 1,  0,  32'h0000_0100, 32'h0};
    vecs[2]  = '{0, 0, 32'h0000_0002, 2'd1, 1, 32'h0,          32'h8011_2233, 0,    32'hFFFF_8011, 0, 3,  1, 0, 1,  0,  32'h0000_0000, 32'h0};
    vecs[3]  = '{0, 0, 32'h0000_0003, 2'd1, 1, 32'h0,          32'h8011_2233, 0,    32'h0,         1, 1,  0, 0, 0,  0,  32'h0,         32'h0};
    vecs[4]  = '{0, 0, 32'h0000_0006, 2'd2, 0, 32'h0,          32'h8011_2233, 0,    32'h0,         1, 1,  0, 0, 0,  0,  32'h0,         32'h0};
    vecs[5]  = '{0, 0, 32'h0000_0008, 2'd2, 0, 32'h0,          32'hDEAD_BEEF, 0,    32'hDEAD_BEEF, 0, 3,  1, 0, 1,  0,  32'h0000_0008, 32'h0};
    vecs[6]  = '{0, 1, 32'h0000_0201, 2'd1, 0, 32'h0000_BEEF,  32'h1122_3344, 0,    32'h0,         0, 4,  1, 1, 1,  1,  32'h0000_0200, 32'h11BE_EF44};
    vecs[7]  = '{0, 1, 32'h0000_0302, 2'd0, 0, 32'hFFFF_FFAB,  32'h1122_3344, 0,    32'h0,         0, 4,  1, 1, 1,  1,  32'h0000_0300, 32'h11AB_3344};
    vecs[8]  = '{0, 1, 32'h0000_0400, 2'd2, 0, 32'hCAFE_F00D,  32'h0,         5,    32'h0,         0, 8,  0, 1, 0,  6,  32'h0000_0400, 32'hCAFE_F00D};
    vecs[9]  = '{0, 0, 32'h0000_0001, 2'd1, 0, 32'h0,          32'hAABB_CCDD, 0,    32'h0000_BBCC, 0, 3,  1, 0, 1,  0,  32'h0000_0000, 32'h0};
    vecs[10] = '{0, 1, 32'h0000_0402, 2'd2, 0, 32'h1234_5678,  32'h0,         0,    32'h0,         1, 1,  0, 0, 0,  0,  32'h0,         32'h0};
    vecs[11] = '{0, 0, 32'h0000_0000, 2'd1, 1, 32'h0,          32'h1234_8765, 2,    32'hFFFF_8765, 0, 5,  1, 0, 3,  0,  32'h0000_0000, 32'h0};
    vecs[12] = '{1, 0, 32'h0000_0500, 2'd2, 0, 32'h0,          32'h0,         1000, 32'h0,         1, 6,  0, 0, 4,  0,  32'h0,         32'h0};
    vecs[13] = '{1, 0, 32'h0000_0504, 2'd2, 0, 32'h0,          32'h5566_7788, 0,    32'h5566_7788, 0, 3,  1, 0, 1,  0,  32'h0000_0504, 32'h0};
    vecs[14] = '{0, 0, 32'h0000_0600, 2'd2, 0, 32'h0,          32'h0,         1000, 32'h0,         1, 18, 0, 0, 16, 0,  32'h0,         32'h0};

    reset_n = 0; reqValid = 0; reqWrite = 0; reqAddr = '0; reqLen = '0;
    reqSignExtend = 0; reqWData = '0; memRData = '0; memAck = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_memRead",   {31'b0, a_memRead},   32'd0);
    chk("rst_memWrite",  {31'b0, a_memWrite},  32'd0);
    chk("rst_respValid", {31'b0, a_respValid}, 32'd0);
    chk("rst_respError", {31'b0, a_respError}, 32'd0);
    chk("rst_respData",  a_respData,           32'd0);
    chk("rst_memAddr",   a_memAddr,            32'd0);
    chk("rst_memWData",  a_memWData,           32'd0);
    reset_n = 1;
    @(negedge clk);
    chk("rst_reqReady",  {31'b0, a_reqReady},  32'd1);

    for (int i = 0; i < 15; i++) begin
      do_txn(vecs[i]);
      chk($sformatf("v%0d_lat", i),    got_lat,             vecs[i].exp_lat);
      chk($sformatf("v%0d_data", i),   got_data,            vecs[i].exp_data);
      chk($sformatf("v%0d_err", i),    {31'b0, got_err},    {31'b0, vecs[i].exp_err});
      chk($sformatf("v%0d_reads", i),  got_reads,           vecs[i].exp_reads);
      chk($sformatf("v%0d_writes", i), got_writes,          vecs[i].exp_writes);
      chk($sformatf("v%0d_rdcyc", i),  got_rdc,             vecs[i].exp_rdc);
      chk($sformatf("v%0d_wrcyc", i),  got_wrc,             vecs[i].exp_wrc);
      chk($sformatf("v%0d_pulse", i),  {31'b0, got_tail},   32'd0);
      chk($sformatf("v%0d_both", i),   {31'b0, both_high},  32'd0);
      chk($sformatf("v%0d_stable", i), {31'b0, unstable},   32'd0);
      if (vecs[i].exp_reads + vecs[i].exp_writes > 0)
        chk($sformatf("v%0d_addr", i), got_addr, vecs[i].exp_addr);
      if (vecs[i].exp_writes > 0)
        chk($sformatf("v%0d_wdata", i), got_wdata, vecs[i].exp_wdata);
    end

    // Reset while a word store is waiting in the write phase.
    wait_idle();
    use_b = 0;
    reqValid = 1; reqWrite = 1; reqAddr = 32'h0000_0700; reqLen = 2'd2; reqWData = 32'h1234_5678;
    @(negedge clk);
    reqValid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rstwr_pre_memWrite", {31'b0, a_memWrite}, 32'd1);
    reset_n = 0;
    @(negedge clk);
    chk("rstwr_memWrite",  {31'b0, a_memWrite},  32'd0);
    chk("rstwr_reqReady",  {31'b0, a_reqReady},  32'd1);
    chk("rstwr_respValid", {31'b0, a_respValid}, 32'd0);
    chk("rstwr_memAddr",   a_memAddr,            32'd0);
    reset_n = 1;
    memAck = 1;
    @(negedge clk);
    memAck = 0;
    begin
      logic activity = 0;
      for (int n = 0; n < 5; n++) begin
        if (a_respValid || a_memRead || a_memWrite || !a_reqReady) activity = 1;
        @(negedge clk);
      end
      chk("rstwr_late_ack", {31'b0, activity}, 32'd0);
    end

    // Normal operation after the reset.
    do_txn('{0, 0, 32'h0000_0804, 2'd2, 0, 32'h0, 32'h0BAD_F00D, 0, 32'h0BAD_F00D,
             0, 3, 1, 0, 1, 0, 32'h0000_0804, 32'h0});
    chk("post_rst_lat",  got_lat,  32'd3);
    chk("post_rst_data", got_data, 32'h0BAD_F00D);
    chk("post_rst_addr", got_addr, 32'h0000_0804);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences one load/store at a time between the CPU execute stage and a word-wide, word-aligned memory bus.
- Loads are a single aligned word read. The existing sub-word read/write datapath (LoadStore) extracts and sign-extends the byte or half.
- Byte/half stores become read-modify-write: read the word, merge via LoadStore, write it back. Word stores are a single write.
- Flags misaligned accesses and bus timeouts as errors.

Parameters:
TIMEOUT_CYCLES, 16, cycles to wait for memAck per bus phase before aborting with error; 0 disables timeout.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
reqValid  in  1  CPU request valid
reqReady  out  1  controller can accept a request (state IDLE)
reqWrite  in  1  1=store, 0=load
reqAddr  in  32  byte address
reqLen  in  2  `LOAD_STORE_BYTE / `LOAD_STORE_HALF / `LOAD_STORE_WORD
reqSignExtend  in  1  sign-extend sub-word load
reqWData  in  32  store data, right-justified
respValid  out  1  one-cycle completion pulse
respData  out  32  load result; 0 for stores and errors
respError  out  1  valid with respValid: misaligned or timeout
memAddr  out  32  {addr[31:2],2'b00}
memRead  out  1  read strobe, held until memAck
memWrite  out  1  write strobe, held until memAck
memWData  out  32  full write word
memRData  in  32  read data, valid with memAck
memAck  in  1  bus completion, single cycle

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE; memRead=memWrite=respValid=respError=0; respData=0; memAddr=0; memWData=0; timeout counter=0. reqReady=1 from the first edge after reset deasserts. Reset mid-transaction abandons the bus phase; strobes drop on that edge.
- reqReady = (state==IDLE), combinational. All other outputs are registered.
- Handshake: accept when reqValid & reqReady. Latch addr, len, write, signExtend, wdata.
- Misalignment check on accept:
  - half with addr[1:0]==3 → error.
  - word with addr[1:0]!=0 → error.
  - byte never errors.
  - Error → next state RESP, respError=1, no bus activity.
- States:
  - IDLE:
    - load → RD;
    - word store → WR, with memWData=reqWData;
    - byte/half store → RD;
    - misaligned → RESP.
  - RD: memRead=1, memAddr stable. On memAck, capture memRData into dataReg.
    - For a load: respData = LoadStore.readDataOut(dataReg, offset, len, signExtend); go to RESP.
    - For a store: memWData = LoadStore.writeDataOut(dataReg, offset, len, wdata); go to WR.
  - WR: memWrite=1, memAddr/memWData stable. On memAck → RESP.
  - RESP: respValid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Strobes are registered: asserted the cycle after the state is entered, deasserted on the edge memAck is sampled. memRead and memWrite are never both high.
- memAck outside RD/WR is ignored.
- Timeout: counter clears on entering RD/WR and increments each cycle without memAck. When counter==TIMEOUT_CYCLES-1 with no ack: drop the strobe and go to RESP with respError=1. memAck in the same cycle as expiry wins (normal completion).
- Minimum latency from accept to respValid: load 3 cycles (zero-wait ack), word store 3, sub-word store 4, misaligned 1.
- offset = latched addr[1:0]. A new request is only accepted from IDLE; back-to-back requests are spaced by at least one IDLE cycle.

Decomposition:
- Constants in riscvdefs.vh: `LOAD_STORE_BYTE=2'd0, `LOAD_STORE_HALF=2'd1, `LOAD_STORE_WORD=2'd2. Also state encodings MAC_IDLE/MAC_RD/MAC_WR/MAC_RESP.
- One sub-module instance: the existing LoadStore. Its dataIn is driven from dataReg for the load result and from the memRData capture path on the RD ack for the store merge. readLen and writeLen are both driven by the latched len.
- FSM and timeout counter live in mem_access_ctrl itself.

Test Plan:
- Signed byte load, addr 0x103, sign=1, memRData 0x80112233, zero-wait ack → respData 0xFFFFFF80, respError 0, respValid 3 cycles after accept, memAddr 0x100.
- Half store, addr 0x201, wdata 0x0000BEEF, read returns 0x11223344 → one read then one write at 0x200, memWData 0x11BEEF44, respData 0.
- Word load at addr 0x006 → respValid next cycle with respError=1, memRead/memWrite never asserted. Half load at 0x003 gives the same result; half at 0x002 succeeds.
- Word store, ack delayed 5 cycles → memWrite held high for 6 cycles with stable memAddr/memWData. No read phase occurs.
- TIMEOUT_CYCLES=4, no memAck on load → memRead deasserts after 4 cycles, respError=1. A subsequent request is accepted normally.
- reset_n low for one cycle while in WR → next cycle memWrite=0, reqReady=1, no respValid. A late memAck is ignored.
